// File: rtl/simon_sequencer.sv
// Simon colour sequencer: stores the growing colour sequence, replays it with
// fixed tone-on/tone-off timing, then checks player guesses step by step.
module simon_sequencer #(
  parameter int DEPTH     = 32,
  parameter int LEN_W     = 6,
  parameter int ON_TICKS  = 37500000,
  parameter int OFF_TICKS = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             append,
  input  logic [1:0]       append_color,
  input  logic             play,
  input  logic             guess_valid,
  input  logic [1:0]       guess_color,
  output logic [1:0]       color,
  output logic             tone_en,
  output logic             busy,
  output logic             play_done,
  output logic             guess_ok,
  output logic             guess_wrong,
  output logic             round_won,
  output logic [LEN_W-1:0] length,
  output logic [LEN_W-1:0] guess_idx,
  output logic             full
);

  // state       | meaning
  // IDLE        | accepting append/play, outputs quiet
  // PLAY_ON     | sounding mem[play_idx] for ON_TICKS cycles
  // PLAY_OFF    | silence for OFF_TICKS cycles after each tone
  // AWAIT_GUESS | comparing player guesses against mem[guess_idx]
  typedef enum logic [1:0] {IDLE, PLAY_ON, PLAY_OFF, AWAIT_GUESS} state_t;

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]      ON_LAST  = 32'(ON_TICKS - 1);
  localparam logic [31:0]      OFF_LAST = 32'(OFF_TICKS - 1);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

  state_t           state;
  logic [1:0]       mem [DEPTH];
  logic [LEN_W-1:0] play_idx;
  logic [31:0]      tick;

  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] play_next;
  logic             mem_we;

  assign full      = (length == DEPTH_L);
  assign busy      = (state != IDLE);
  assign last_idx  = length - ONE_L;
  assign play_next = play_idx + ONE_L;
  assign mem_we    = !reset && !clear && (state == IDLE) && append && !full;

  // Storage needs no reset; only entries below length are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[length[IDX_W-1:0]] <= append_color;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      length      <= '0;
      guess_idx   <= '0;
      play_idx    <= '0;
      tick        <= '0;
      color       <= 2'd0;
      tone_en     <= 1'b0;
      play_done   <= 1'b0;
      guess_ok    <= 1'b0;
      guess_wrong <= 1'b0;
      round_won   <= 1'b0;
    end else begin
      play_done   <= 1'b0;
      guess_ok    <= 1'b0;
      guess_wrong <= 1'b0;
      round_won   <= 1'b0;

      if (clear) begin
        state     <= IDLE;
        length    <= '0;
        guess_idx <= '0;
        play_idx  <= '0;
        tick      <= '0;
        color     <= 2'd0;
        tone_en   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // append wins over a simultaneous play
            if (append) begin
              if (!full) length <= length + ONE_L;
            end else if (play && (length != '0)) begin
              state    <= PLAY_ON;
              play_idx <= '0;
              tick     <= '0;
              tone_en  <= 1'b1;
              color    <= mem[0];
            end
          end

          PLAY_ON: begin
            if (tick == ON_LAST) begin
              state   <= PLAY_OFF;
              tick    <= '0;
              tone_en <= 1'b0;
              color   <= 2'd0;
            end else begin
              tick <= tick + 32'd1;
            end
          end

          PLAY_OFF: begin
            if (tick == OFF_LAST) begin
              tick <= '0;
              if (play_idx == last_idx) begin
                state     <= AWAIT_GUESS;
                play_done <= 1'b1;
                guess_idx <= '0;
              end else begin
                state    <= PLAY_ON;
                play_idx <= play_next;
                tone_en  <= 1'b1;
                color    <= mem[play_next[IDX_W-1:0]];
              end
            end else begin
              tick <= tick + 32'd1;
            end
          end

          AWAIT_GUESS: begin
            if (guess_valid) begin
              if (guess_color == mem[guess_idx[IDX_W-1:0]]) begin
                guess_ok <= 1'b1;
                if (guess_idx == last_idx) begin
                  round_won <= 1'b1;
                  guess_idx <= '0;
                  state     <= IDLE;
                end else begin
                  guess_idx <= guess_idx + ONE_L;
                end
              end else begin
                guess_wrong <= 1'b1;
                guess_idx   <= '0;
                state       <= IDLE;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer: fixed scenarios plus randomized
// rounds compared against a queue-based model of the sequence and its timing.
module tb_simon_sequencer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 3;
  localparam int ON    = 4;
  localparam int OFF   = 2;

  logic             clk = 1'b0;
  logic             reset, clear, append, play, guess_valid;
  logic [1:0]       append_color, guess_color;
  logic [1:0]       color;
  logic             tone_en, busy, play_done, guess_ok, guess_wrong, round_won, full;
  logic [LEN_W-1:0] length, guess_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] model_seq[$];
  int         model_gidx;

  simon_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ON_TICKS(ON), .OFF_TICKS(OFF)) dut (
    .clk(clk), .reset(reset), .clear(clear), .append(append), .append_color(append_color),
    .play(play), .guess_valid(guess_valid), .guess_color(guess_color), .color(color),
    .tone_en(tone_en), .busy(busy), .play_done(play_done), .guess_ok(guess_ok),
    .guess_wrong(guess_wrong), .round_won(round_won), .length(length),
    .guess_idx(guess_idx), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_seq.delete();
    model_gidx = 0;
  endtask

  task automatic do_append(input logic [1:0] c);
    append = 1'b1;
    append_color = c;
    tick();
    append = 1'b0;
    if (model_seq.size() < DEPTH) model_seq.push_back(c);
    n_tests++;
    if (length !== LEN_W'(model_seq.size()) || full !== (model_seq.size() == DEPTH)) begin
      n_fail++;
      $display("FAIL append: length=%0d full=%b, expected length=%0d full=%b",
               length, full, model_seq.size(), (model_seq.size() == DEPTH));
    end
  endtask

  // Expected waveform derived from cycle arithmetic: each colour occupies ON+OFF cycles.
  task automatic run_playback();
    int per, total, idx, ph;
    logic       exp_tone;
    logic [1:0] exp_col;
    logic [4:0] exp_v, got_v;
    per   = ON + OFF;
    total = model_seq.size() * per;
    play  = 1'b1;
    tick();
    play  = 1'b0;
    for (int k = 1; k <= total; k++) begin
      idx      = (k - 1) / per;
      ph       = (k - 1) % per;
      exp_tone = (ph < ON);
      exp_col  = exp_tone ? model_seq[idx] : 2'd0;
      exp_v    = {exp_tone, exp_col, 1'b1, 1'b0};
      got_v    = {tone_en, color, busy, play_done};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL playback cycle %0d: {tone,color,busy,done}=%b expected %b", k, got_v, exp_v);
      end
      tick();
    end
    n_tests++;
    if ({tone_en, color, busy, play_done, guess_idx} !== {1'b0, 2'd0, 1'b1, 1'b1, LEN_W'(0)}) begin
      n_fail++;
      $display("FAIL play_done: tone=%b color=%0d busy=%b done=%b gidx=%0d expected 0 0 1 1 0",
               tone_en, color, busy, play_done, guess_idx);
    end
    model_gidx = 0;
    tick();
    n_tests++;
    if ({play_done, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL play_done width: done=%b busy=%b expected done=0 busy=1", play_done, busy);
    end
  endtask

  task automatic do_guess(input logic [1:0] c);
    logic exp_ok, exp_wrong, exp_won, exp_busy;
    exp_ok    = (c == model_seq[model_gidx]);
    exp_wrong = !exp_ok;
    exp_won   = exp_ok && (model_gidx == model_seq.size() - 1);
    if (exp_ok && !exp_won) model_gidx++;
    else model_gidx = 0;
    exp_busy  = exp_ok && !exp_won;
    guess_valid = 1'b1;
    guess_color = c;
    tick();
    guess_valid = 1'b0;
    n_tests++;
    if ({guess_ok, guess_wrong, round_won, busy, guess_idx} !==
        {exp_ok, exp_wrong, exp_won, exp_busy, LEN_W'(model_gidx)}) begin
      n_fail++;
      $display("FAIL guess %0d: ok=%b wrong=%b won=%b busy=%b gidx=%0d expected %b %b %b %b %0d",
               c, guess_ok, guess_wrong, round_won, busy, guess_idx,
               exp_ok, exp_wrong, exp_won, exp_busy, model_gidx);
    end
    tick();
    n_tests++;
    if ({guess_ok, guess_wrong, round_won} !== 3'b000) begin
      n_fail++;
      $display("FAIL guess pulse width: ok=%b wrong=%b won=%b expected 000",
               guess_ok, guess_wrong, round_won);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({color, tone_en, busy, play_done, guess_ok, guess_wrong, round_won, length, guess_idx, full} !== '0) begin
      n_fail++;
      $display("FAIL reset: color=%0d tone=%b busy=%b length=%0d gidx=%0d full=%b expected all 0",
               color, tone_en, busy, length, guess_idx, full);
    end
    reset = 1'b0;
    model_seq.delete();
    model_gidx = 0;
    tick();
  endtask

  task automatic test_playback();
    do_append(2'd2);
    do_append(2'd0);
    do_append(2'd3);
    run_playback();
  endtask

  task automatic test_guess_correct();
    do_guess(2'd2);
    do_guess(2'd0);
    do_guess(2'd3);
    n_tests++;
    if (length !== 3'd3) begin
      n_fail++;
      $display("FAIL length kept: length=%0d expected 3", length);
    end
  endtask

  task automatic test_guess_wrong();
    run_playback();
    do_guess(2'd2);
    do_guess(2'd1);
  endtask

  task automatic test_guess_ignored();
    guess_valid = 1'b1;
    guess_color = model_seq[0];
    tick();
    guess_valid = 1'b0;
    n_tests++;
    if ({guess_ok, guess_wrong, round_won, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle guess: ok=%b wrong=%b won=%b busy=%b expected 0000",
               guess_ok, guess_wrong, round_won, busy);
    end
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) do_append(2'($urandom_range(0, 3)));
    n_tests++;
    if (length !== 3'd4 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full: length=%0d full=%b expected 4 1", length, full);
    end
    run_playback();
    do_guess(model_seq[0] ^ 2'd1);
  endtask

  task automatic test_clear_mid_play();
    do_clear();
    do_append(2'd1);
    do_append(2'd3);
    do_append(2'd2);
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (ON + OFF + 2) tick();
    n_tests++;
    if ({tone_en, color} !== 3'b111) begin
      n_fail++;
      $display("FAIL tone 2 on: tone=%b color=%0d expected 1 3", tone_en, color);
    end
    do_clear();
    n_tests++;
    if ({tone_en, color, busy, length, guess_idx} !== '0) begin
      n_fail++;
      $display("FAIL clear: tone=%b color=%0d busy=%b length=%0d gidx=%0d expected all 0",
               tone_en, color, busy, length, guess_idx);
    end
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    n_tests++;
    if ({busy, tone_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL play when empty: busy=%b tone=%b expected 0 0", busy, tone_en);
    end
  endtask

  task automatic test_play_append_same();
    logic [1:0] c;
    do_clear();
    c = 2'($urandom_range(0, 3));
    play = 1'b1;
    append = 1'b1;
    append_color = c;
    tick();
    play = 1'b0;
    append = 1'b0;
    model_seq.push_back(c);
    tick();
    n_tests++;
    if ({length, busy, tone_en} !== {3'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL play+append: length=%0d busy=%b tone=%b expected 1 0 0", length, busy, tone_en);
    end
    run_playback();
  endtask

  task automatic test_reset_in_await();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({color, tone_en, busy, play_done, guess_ok, guess_wrong, round_won, length, guess_idx, full} !== '0) begin
      n_fail++;
      $display("FAIL reset in await: busy=%b length=%0d gidx=%0d expected all 0", busy, length, guess_idx);
    end
    reset = 1'b0;
    model_seq.delete();
    model_gidx = 0;
    tick();
  endtask

  task automatic test_random_rounds();
    int n, wrong_at;
    for (int it = 0; it < 20; it++) begin
      do_clear();
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) do_append(2'($urandom_range(0, 3)));
      run_playback();
      wrong_at = $urandom_range(0, model_seq.size());
      for (int i = 0; i < model_seq.size(); i++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (i == wrong_at) begin
          do_guess(model_seq[i] ^ 2'($urandom_range(1, 3)));
          break;
        end
        do_guess(model_seq[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; append = 1'b0; play = 1'b0; guess_valid = 1'b0;
    append_color = 2'd0; guess_color = 2'd0;
    model_gidx = 0;
    test_reset();
    test_playback();
    test_guess_correct();
    test_guess_ignored();
    test_guess_wrong();
    test_full();
    test_clear_mid_play();
    test_play_append_same();
    test_reset_in_await();
    test_random_rounds();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
